// File: rtl/trigger_capture.sv
// Edge-triggered single-frame capture with pre-trigger history, stored in a circular
// sample RAM, with a trigger-aligned random-access read port for the display stage.
module trigger_capture #(
    parameter int DW           = 10,
    parameter int DEPTH        = 640,
    parameter int AW           = 10,
    parameter int PRETRIG      = 64,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic [DW-1:0] datain,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_slope,
    input  logic          auto_mode,
    input  logic          arm,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          auto_trig
);

    localparam int TW = $clog2(AUTO_TIMEOUT + 1);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BACK_OFF  = (AW+1)'(DEPTH - PRETRIG);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FILL_LAST = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(AUTO_TIMEOUT - 1);
    localparam bit            POST_ONE  = (DEPTH - PRETRIG) == 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t        state_q,      state_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] trig_ptr_q,   trig_ptr_d;
    logic [AW-1:0] cnt_q,        cnt_d;
    logic [TW-1:0] tmo_cnt_q,    tmo_cnt_d;
    logic [DW-1:0] prev_q,       prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic          auto_trig_q,  auto_trig_d;
    logic [DW-1:0] rd_data_q,    rd_data_d;

    logic [DW-1:0] mem [DEPTH];

    logic          capturing;
    logic          wr_en;
    logic          edge_hit;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW:0]   start_sum;
    logic [AW-1:0] start_ptr;
    logic [AW:0]   rd_sum;
    logic [AW-1:0] rd_idx;
    logic          rd_ok;

    assign capturing  = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
    assign wr_en      = capturing && sample_en;
    assign wr_ptr_nxt = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);

    assign edge_hit = prev_valid_q && (trig_slope
                      ? (prev_q < trig_level) && (datain >= trig_level)
                      : (prev_q > trig_level) && (datain <= trig_level));

    // Display index 0 is PRETRIG samples before the trigger; modulo by conditional subtract.
    assign start_sum = {1'b0, trig_ptr_q} + BACK_OFF;
    assign start_ptr = (start_sum >= DEPTH_W) ? AW'(start_sum - DEPTH_W) : AW'(start_sum);
    assign rd_sum    = {1'b0, start_ptr} + {1'b0, rd_addr};
    assign rd_idx    = (rd_sum >= DEPTH_W) ? AW'(rd_sum - DEPTH_W) : AW'(rd_sum);
    assign rd_ok     = {1'b0, rd_addr} < DEPTH_W;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        trig_ptr_d   = trig_ptr_q;
        cnt_d        = cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        auto_trig_d  = auto_trig_q;
        rd_data_d    = rd_ok ? mem[rd_idx] : '0;

        if (wr_en) begin
            wr_ptr_d     = wr_ptr_nxt;
            prev_d       = datain;
            prev_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d      = S_FILL;
                    cnt_d        = '0;
                    tmo_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                    auto_trig_d  = 1'b0;
                end
            end
            S_FILL: begin
                if (wr_en) begin
                    if (cnt_q == FILL_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (wr_en) begin
                    if (edge_hit || (auto_mode && (tmo_cnt_q == TMO_LAST))) begin
                        trig_ptr_d  = wr_ptr_q;
                        auto_trig_d = !edge_hit;
                        cnt_d       = AW'(1);
                        state_d     = POST_ONE ? S_DONE : S_POST;
                    end else if (tmo_cnt_q != TMO_LAST) begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
            end
            S_POST: begin
                if (wr_en) begin
                    if (cnt_q == POST_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            cnt_q        <= '0;
            tmo_cnt_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            auto_trig_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_ptr_q   <= trig_ptr_d;
            cnt_q        <= cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            auto_trig_q  <= auto_trig_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // NOTE: the sample RAM is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= datain;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = capturing;
    assign done      = (state_q == S_DONE);
    assign auto_trig = auto_trig_q;

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Sits directly downstream of the AC/DC coupling stage.
- Consumes its 10-bit coupled sample stream and runs an edge trigger (with pre-trigger history) against a programmable level.
- Captures one screen of DEPTH samples into an internal circular RAM.
- Exposes a random-access read port so the display/plot stage can draw a stable, trigger-aligned frame.

Parameters:
- DW, 10, sample width (matches the coupling stage output).
- DEPTH, 640, samples per frame (one per horizontal pixel).
- AW, 10, address/counter width; must satisfy 2^AW >= DEPTH.
- PRETRIG, 64, samples shown before the trigger point; 1 <= PRETRIG < DEPTH.
- AUTO_TIMEOUT, 4096, sample strobes to wait in auto mode before forcing a trigger.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  strobe; datain is valid on this cycle.
- datain  input  DW  coupled sample from the AC/DC stage.
- trig_level  input  DW  trigger threshold, unsigned.
- trig_slope  input  1  1 = rising edge, 0 = falling edge.
- auto_mode  input  1  1 = force a trigger after AUTO_TIMEOUT.
- arm  input  1  single-cycle request to start a capture.
- rd_addr  input  AW  display-order read index, 0..DEPTH-1.
- rd_data  output  DW  sample at rd_addr; 1-cycle read latency.
- busy  output  1  capture in progress (FILL, WAIT_TRIG or POST).
- done  output  1  frame complete and stable for readout.
- auto_trig  output  1  last frame was triggered by timeout, not by an edge.

Behaviour:
- Reset (sync, highest priority): state=IDLE, busy=0, done=0, auto_trig=0, rd_data=0, wr_ptr=0, all counters=0, prev_valid=0. RAM contents are not cleared.
- RAM: DEPTH x DW, single write port, synchronous read.
  - Writes occur only on cycles where sample_en=1 in FILL, WAIT_TRIG or POST, at wr_ptr.
  - wr_ptr increments after each write and wraps DEPTH-1 -> 0 (DEPTH need not be a power of two).
- prev register:
  - Loads datain on every sample_en in FILL/WAIT_TRIG/POST.
  - prev_valid sets on the first such load and clears on arm acceptance.
- Edge detection:
  - Rising: prev_valid and prev < trig_level and datain >= trig_level.
  - Falling: prev_valid and prev > trig_level and datain <= trig_level.
  - Compares are unsigned, DW bits.
- States:
  - IDLE: busy=0. arm -> FILL; clears done, auto_trig, counters and prev_valid; wr_ptr unchanged.
  - FILL: write PRETRIG samples. Edges here are ignored. After the PRETRIG-th write -> WAIT_TRIG.
  - WAIT_TRIG: keep writing circularly; tmo_cnt counts strobes.
    - On a sample where an edge is detected: that sample is the trigger sample. Latch trig_ptr = wr_ptr for that write; -> POST; post_cnt = 1.
    - Else if auto_mode and tmo_cnt == AUTO_TIMEOUT-1 on a strobe: the same sample is forced as the trigger sample; set auto_trig=1; -> POST.
    - tmo_cnt saturates when auto_mode=0.
  - POST: write until DEPTH-PRETRIG samples total have been written, counting the trigger sample. On the last write -> DONE.
  - DONE: done=1, busy=0, no writes. arm -> FILL (re-arm); done drops the next cycle.
- arm handling: arm is ignored in FILL, WAIT_TRIG and POST. rst and arm in the same cycle: rst wins.
- Readout:
  - start_ptr = (trig_ptr + DEPTH - PRETRIG) mod DEPTH.
  - The cycle after rd_addr is presented: rd_data = RAM[(start_ptr + rd_addr) mod DEPTH].
  - If rd_addr >= DEPTH, rd_data = 0.
  - Reads are legal in any state; contents are only defined while done=1.
- Width rules:
  - The modulo add uses AW+1 bits with a conditional subtract of DEPTH; no divider.
  - tmo_cnt is wide enough for AUTO_TIMEOUT.
- Reset mid-capture: the capture is abandoned immediately, outputs return to reset values, and the next arm starts a clean capture.

Test Plan:
- Rising-edge ramp, PRETRIG=64, DEPTH=640, level=300, datain = strobe index n mod 1024, arm before n=0 -> trigger on n=300; done rises after the write of n=875; rd_addr 0 -> 236, rd_addr 64 -> 300, rd_addr 639 -> 875; auto_trig=0.
- Edge inside FILL, level=10, same ramp -> the crossing at n=10 is ignored. Input then falls to 0 and ramps again; the trigger fires on the later crossing, and rd_addr 64 reads 10 from the second ramp.
- Falling slope, square wave 800/200 with period 100 strobes, level=500 -> the trigger sample reads 200 at rd_addr 64 and 800 at rd_addr 63.
- Auto timeout, AUTO_TIMEOUT=1000, constant datain=100, level=500, auto_mode=1 -> the 1000th WAIT_TRIG strobe is forced as the trigger; done after 575 further strobes; auto_trig=1; all 640 reads = 100. With auto_mode=0 the block stays busy indefinitely.
- Protocol and boundaries:
  - arm pulsed during WAIT_TRIG and POST -> no effect.
  - arm in DONE -> done=0 next cycle and a new frame is captured.
  - rd_addr=700 -> rd_data=0.
  - sample_en gaps of 3 idle cycles -> captured data identical to the gap-free run.
- rst asserted mid-POST, with arm also high in the same cycle -> next cycle state IDLE, busy=0, done=0, rd_data=0; a later arm yields the correct scenario-1 frame.
